// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// DmemResponder (module dmem_responder)
//
// Purpose:
//    Data-memory slave for the memory stage of the 5-stage RISC-V pipeline.
//    The memory stage issues one request at a time over a valid/ready
//    handshake. The responder answers after a configurable access latency
//    with load data or an error flag. Stores are byte-lane masked and commit
//    on the cycle the request is accepted.
//
// Parameters:
//    DEPTH_WORDS  number of 32-bit words (byte range 0 .. DEPTH_WORDS*4-1)
//    LATENCY      cycles from request accept to rsp_valid, must be >= 1
//
// Ports:
//    clk        in   1   clock, all logic on the rising edge
//    rst        in   1   synchronous active-low reset
//    req_valid  in   1   request present
//    req_ready  out  1   responder can accept (IDLE and not in reset)
//    req_we     in   1   1 = store, 0 = load
//    req_addr   in   32  byte address
//    req_wdata  in   32  store data
//    req_be     in   4   byte-lane write enables, bit i -> wdata[8i+7:8i]
//    rsp_valid  out  1   response present
//    rsp_ready  in   1   initiator takes the response
//    rsp_rdata  out  32  load data, zero for stores and errors
//    rsp_err    out  1   misaligned or out-of-range access
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic           r_rspValid;
    logic [31:0]    r_rspRdata;
    logic           r_rspErr;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_accept;
    logic           w_misaligned;
    logic           w_outOfRange;
    logic           w_err;
    logic [AW-1:0]  w_index;

    // The request side is open only while idle and out of reset, so a request
    // presented during reset or while a response is pending is simply ignored.
    assign req_ready    = (r_state == IDLE) && rst;
    assign w_accept     = req_valid && req_ready;

    // Address qualification. The range test is done one bit wider than the
    // address so that a depth reaching the top of the 32-bit space cannot
    // overflow the limit constant.
    assign w_misaligned = (req_addr[1:0] != 2'b00);
    assign w_outOfRange = ({1'b0, req_addr} >= ADDR_LIMIT);
    assign w_err        = w_misaligned || w_outOfRange;
    assign w_index      = req_addr[AW+1:2];

    assign rsp_valid    = r_rspValid;
    assign rsp_rdata    = r_rspRdata;
    assign rsp_err      = r_rspErr;

    // Word array with byte-lane writes. It has no reset on purpose: contents
    // survive a reset, and a store accepted before reset stays committed.
    // Erroneous stores never touch the array; an all-zero lane mask is a
    // legal store that changes nothing.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    r_mem[w_index][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request/response sequencer. Load data is sampled from the array on the
    // accept edge, so the response register already holds the final value
    // while the latency counter runs. With LATENCY of one the BUSY state is
    // skipped entirely. The response is held until the initiator takes it,
    // and the return to IDLE happens on that same edge so a new request can
    // only be accepted on the following one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rspErr <= w_err;
                        if (w_err || req_we) begin
                            r_rspRdata <= '0;
                        end else begin
                            r_rspRdata <= r_mem[w_index];
                        end
                        if (LATENCY > 1) begin
                            r_state <= BUSY;
                            r_count <= CW'(LATENCY - 1);
                        end else begin
                            r_state    <= RESP;
                            r_rspValid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state    <= RESP;
                        r_rspValid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state    <= IDLE;
                        r_rspValid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_rspValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// Testbench for dmem_responder.
// Two responders share the clock and reset: index 0 uses LATENCY=2, index 1
// uses LATENCY=1. Both use DEPTH_WORDS=1024. Inputs are driven on the falling
// edge and outputs sampled on the falling edge, away from the active edge.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid [2];
    logic        reqReady [2];
    logic        reqWe    [2];
    logic [31:0] reqAddr  [2];
    logic [31:0] reqWdata [2];
    logic [3:0]  reqBe    [2];
    logic        rspValid [2];
    logic        rspReady [2];
    logic [31:0] rspRdata [2];
    logic        rspErr   [2];

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] expRdata;
        logic        expErr;
    } vector_t;

    vector_t vectors [$];

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid[0]),
        .req_ready (reqReady[0]),
        .req_we    (reqWe[0]),
        .req_addr  (reqAddr[0]),
        .req_wdata (reqWdata[0]),
        .req_be    (reqBe[0]),
        .rsp_valid (rspValid[0]),
        .rsp_ready (rspReady[0]),
        .rsp_rdata (rspRdata[0]),
        .rsp_err   (rspErr[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid[1]),
        .req_ready (reqReady[1]),
        .req_we    (reqWe[1]),
        .req_addr  (reqAddr[1]),
        .req_wdata (reqWdata[1]),
        .req_be    (reqBe[1]),
        .rsp_valid (rspValid[1]),
        .rsp_ready (rspReady[1]),
        .rsp_rdata (rspRdata[1]),
        .rsp_err   (rspErr[1])
    );

    // One comparison: counts it, and reports a FAIL line on a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Full transaction on responder d: present the request, wait for accept,
    // count cycles until rsp_valid (bounded), capture the response and take it.
    task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output logic [31:0] rdata, output logic err,
                                 output int lat);
        int waitCycles;
        @(negedge clk);
        reqWe[d]    = we;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        reqBe[d]    = be;
        reqValid[d] = 1'b1;
        waitCycles  = 0;
        while (!reqReady[d] && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        @(posedge clk);
        @(negedge clk);
        reqValid[d] = 1'b0;
        lat = 1;
        while (!rspValid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = rspRdata[d];
        err   = rspErr[d];
        rspReady[d] = 1'b1;
        @(negedge clk);
        rspReady[d] = 1'b0;
    endtask

    // Hang guard in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          waitCycles;

        // LATENCY=2 directed vectors: {we, addr, wdata, be, expRdata, expErr}
        vectors.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vectors.push_back('{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
        vectors.push_back('{1'b1, 32'h10,  32'h12345678, 4'h0, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
        vectors.push_back('{1'b1, 32'h0,   32'h11223344, 4'hF, 32'h0,        1'b0});
        vectors.push_back('{1'b1, 32'h1000,32'hCAFEF00D, 4'hF, 32'h0,        1'b1});
        vectors.push_back('{1'b0, 32'h0,   32'h0,        4'h0, 32'h11223344, 1'b0});
        vectors.push_back('{1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1});
        vectors.push_back('{1'b1, 32'h12,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
        vectors.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
        vectors.push_back('{1'b1, 32'h14,  32'hA0B0C0D0, 4'hF, 32'h0,        1'b0});
        vectors.push_back('{1'b1, 32'h14,  32'h55667788, 4'hA, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 32'h14,  32'h0,        4'h0, 32'h55B077D0, 1'b0});
        vectors.push_back('{1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 32'hFFC, 32'h0,        4'h0, 32'h0BADF00D, 1'b0});
        vectors.push_back('{1'b0, 32'h1000,32'h0,        4'h0, 32'h0,        1'b1});

        for (int d = 0; d < 2; d++) begin
            reqValid[d] = 1'b0;
            reqWe[d]    = 1'b0;
            reqAddr[d]  = '0;
            reqWdata[d] = '0;
            reqBe[d]    = '0;
            rspReady[d] = 1'b0;
        end

        // Reset held three cycles with a store request pending.
        rst = 1'b0;
        @(negedge clk);
        reqValid[0] = 1'b1;
        reqWe[0]    = 1'b1;
        reqAddr[0]  = 32'h0;
        reqWdata[0] = 32'hFFFFFFFF;
        reqBe[0]    = 4'hF;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset req_ready", 32'(reqReady[0]), 32'd0);
            checkOutput("reset rsp_valid", 32'(rspValid[0]), 32'd0);
            checkOutput("reset rsp_rdata", rspRdata[0], 32'd0);
            checkOutput("reset rsp_err",   32'(rspErr[0]),   32'd0);
        end
        reqValid[0] = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("release req_ready dut0", 32'(reqReady[0]), 32'd1);
        checkOutput("release req_ready dut1", 32'(reqReady[1]), 32'd1);

        // Table-driven transactions at LATENCY=2.
        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(0, vectors[i].we, vectors[i].addr, vectors[i].wdata,
                          vectors[i].be, rdata, err, lat);
            checkOutput($sformatf("vec%0d rdata", i), rdata, vectors[i].expRdata);
            checkOutput($sformatf("vec%0d err", i), 32'(err), 32'(vectors[i].expErr));
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
        end

        // Response back-pressure: five stalled cycles, with a store attempt
        // presented meanwhile that must be ignored.
        @(negedge clk);
        reqWe[0]    = 1'b0;
        reqAddr[0]  = 32'h10;
        reqValid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqWe[0]    = 1'b1;
        reqWdata[0] = 32'h0;
        reqBe[0]    = 4'hF;
        waitCycles  = 0;
        while (!rspValid[0] && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall%0d rsp_valid", i), 32'(rspValid[0]), 32'd1);
            checkOutput($sformatf("stall%0d rsp_rdata", i), rspRdata[0], 32'hDEADBEAA);
            checkOutput($sformatf("stall%0d rsp_err", i),   32'(rspErr[0]), 32'd0);
            checkOutput($sformatf("stall%0d req_ready", i), 32'(reqReady[0]), 32'd0);
            @(negedge clk);
        end
        rspReady[0] = 1'b1;
        reqValid[0] = 1'b0;
        @(negedge clk);
        rspReady[0] = 1'b0;
        checkOutput("after handshake rsp_valid", 32'(rspValid[0]), 32'd0);
        checkOutput("after handshake req_ready", 32'(reqReady[0]), 32'd1);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rdata, err, lat);
        checkOutput("ignored store rdata", rdata, 32'hDEADBEAA);

        // Reset while BUSY: pending load dropped, store during reset ignored.
        @(negedge clk);
        reqWe[0]    = 1'b0;
        reqAddr[0]  = 32'h0;
        reqValid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        reqWe[0]    = 1'b1;
        reqWdata[0] = 32'hFFFFFFFF;
        reqBe[0]    = 4'hF;
        repeat (3) begin
            @(negedge clk);
            checkOutput("busy reset rsp_valid", 32'(rspValid[0]), 32'd0);
            checkOutput("busy reset req_ready", 32'(reqReady[0]), 32'd0);
        end
        reqValid[0] = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("busy release req_ready", 32'(reqReady[0]), 32'd1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("busy release rsp_valid", 32'(rspValid[0]), 32'd0);
        end
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, rdata, err, lat);
        checkOutput("word0 after reset", rdata, 32'h11223344);

        // LATENCY=1 sweep on the second responder.
        applyStimulus(1, 1'b1, 32'h8, 32'h01020304, 4'hF, rdata, err, lat);
        checkOutput("lat1 store latency", 32'(lat), 32'd1);
        checkOutput("lat1 store err", 32'(err), 32'd0);
        applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'h0, rdata, err, lat);
        checkOutput("lat1 load latency", 32'(lat), 32'd1);
        checkOutput("lat1 load rdata", rdata, 32'h01020304);
        applyStimulus(1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h4, rdata, err, lat);
        applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'h0, rdata, err, lat);
        checkOutput("lat1 lane2 rdata", rdata, 32'h01FF0304);
        applyStimulus(1, 1'b0, 32'h9, 32'h0, 4'h0, rdata, err, lat);
        checkOutput("lat1 misaligned err", 32'(err), 32'd1);
        checkOutput("lat1 misaligned rdata", rdata, 32'd0);
        checkOutput("lat1 misaligned latency", 32'(lat), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
